// File: rtl/pwm_pkg.sv
// Shared register-map constants and FSM state type for the PWM controller.
package pwm_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_PRESCALE = 1;
  localparam int unsigned REG_TOP      = 2;
  localparam int unsigned REG_DUTY0    = 3;

  localparam int unsigned CTRL_EN_BIT  = 7;
  localparam int unsigned CTRL_INV_LSB = 4;

  typedef enum logic {
    IDLE,
    RUN
  } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for pwm_ctrl: counts 0..p and pulses tick on the terminal count.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned REG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [REG_W-1:0] p,
  output logic             tick
);

  logic [REG_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = !clear && (pre_cnt_q == p);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (clear || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ctrl.sv
// Multi-channel PWM generator with double-buffered period/duty registers.
// Optional feature macro: PWM_INVERT_EN (per-channel output invert for channels 0/1).
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned REG_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [16*REG_W-1:0] registers_packed,
  output logic [NUM_CH-1:0]   pwm,
  output logic                period_tick,
  output logic                running
);

  pwm_state_t        state_q, state_d;
  logic [REG_W-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]  p_sh_q, p_sh_d, t_sh_q, t_sh_d;
  logic [REG_W-1:0]  d_sh_q [NUM_CH];
  logic [REG_W-1:0]  d_sh_d [NUM_CH];
  logic [NUM_CH-1:0] en_sh_q, en_sh_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_tick_q, period_tick_d;
  logic [REG_W-1:0]  ctrl_reg;
  logic              go, pre_tick, pre_clear, load;
  logic              unused_regs;
`ifdef PWM_INVERT_EN
  logic [1:0]        inv_sh_q, inv_sh_d;
`endif

  assign ctrl_reg    = registers_packed[REG_CTRL*REG_W +: REG_W];
  assign go          = ctrl_reg[CTRL_EN_BIT];
  assign pre_clear   = (state_q != RUN) || !go;
  assign unused_regs = ^registers_packed;

  pwm_prescaler #(.REG_W(REG_W)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (pre_clear),
    .p     (p_sh_q),
    .tick  (pre_tick)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p_sh_d        = p_sh_q;
    t_sh_d        = t_sh_q;
    d_sh_d        = d_sh_q;
    en_sh_d       = en_sh_q;
    period_tick_d = 1'b0;
    load          = 1'b0;
    pwm_d         = '0;
`ifdef PWM_INVERT_EN
    inv_sh_d      = inv_sh_q;
`endif

    case (state_q)
      IDLE: begin
        load  = 1'b1;
        cnt_d = '0;
        if (go) state_d = RUN;
      end
      RUN: begin
        if (!go) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pre_tick) begin
          if (cnt_q == t_sh_q) begin
            cnt_d         = '0;
            period_tick_d = 1'b1;
            load          = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      p_sh_d  = registers_packed[REG_PRESCALE*REG_W +: REG_W];
      t_sh_d  = registers_packed[REG_TOP*REG_W +: REG_W];
      en_sh_d = ctrl_reg[NUM_CH-1:0];
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        d_sh_d[i] = registers_packed[(REG_DUTY0+i)*REG_W +: REG_W];
      end
`ifdef PWM_INVERT_EN
      inv_sh_d = ctrl_reg[CTRL_INV_LSB +: 2];
`endif
    end

    // Compare on the next count/shadows so pwm_q lines up with cnt_q and the
    // new duty is visible in the same cycle as period_tick.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (state_d == RUN) && en_sh_d[i] && (cnt_d < d_sh_d[i]);
`ifdef PWM_INVERT_EN
      if (i < 2) pwm_d[i] = pwm_d[i] ^ inv_sh_d[i[0]];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      p_sh_q        <= '0;
      t_sh_q        <= '0;
      en_sh_q       <= '0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) d_sh_q[i] <= '0;
`ifdef PWM_INVERT_EN
      inv_sh_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p_sh_q        <= p_sh_d;
      t_sh_q        <= t_sh_d;
      en_sh_q       <= en_sh_d;
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
      for (int unsigned i = 0; i < NUM_CH; i++) d_sh_q[i] <= d_sh_d[i];
`ifdef PWM_INVERT_EN
      inv_sh_q      <= inv_sh_d;
`endif
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = period_tick_q;
  assign running     = (state_q == RUN);

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed self-checking bench for pwm_ctrl (default two channels, 8-bit registers).
module tb_pwm_ctrl;

  logic         clock;
  logic         reset;
  logic [127:0] registers_packed;
  logic [1:0]   pwm;
  logic         period_tick;
  logic         running;

  logic [7:0] regs [16];
  int checks;
  int failures;
  int h0, h1, nt, ft, lt, fh;

  pwm_ctrl #(.NUM_CH(2), .REG_W(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .registers_packed (registers_packed),
    .pwm              (pwm),
    .period_tick      (period_tick),
    .running          (running)
  );

  always #5 clock = ~clock;

  always_comb begin
    registers_packed = '0;
    for (int i = 0; i < 16; i++) registers_packed[i*8 +: 8] = regs[i];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Samples n cycles starting now; index 0 is the current cycle.
  task automatic run_window(input int n, output int hi0, output int hi1, output int nticks,
                            output int first_tick, output int last_tick, output int first_hi0);
    hi0 = 0; hi1 = 0; nticks = 0; first_tick = -1; last_tick = -1; first_hi0 = -1;
    for (int k = 0; k < n; k++) begin
      if (pwm[0] === 1'b1) begin
        hi0++;
        if (first_hi0 < 0) first_hi0 = k;
      end
      if (pwm[1] === 1'b1) hi1++;
      if (period_tick === 1'b1) begin
        nticks++;
        if (first_tick < 0) first_tick = k;
        last_tick = k;
      end
      step();
    end
  endtask

  task automatic start_run(input logic [7:0] ctrl);
    regs[0] = 8'h00;
    step();
    step();
    regs[0] = ctrl;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    regs[0] = 8'h83; regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd3; regs[4] = 8'd7;
    step(); step(); step();
    checks++; if (pwm !== 2'b00) begin failures++; $display("FAIL reset_pwm got=%b exp=00", pwm); end
    checks++; if (period_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", period_tick); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    regs[0] = 8'h00;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd3; regs[4] = 8'd7;
    start_run(8'h83);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL basic_running got=%b exp=1", running); end
    run_window(30, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 9) begin failures++; $display("FAIL basic_hi0 got=%0d exp=9", h0); end
    checks++; if (h1 !== 21) begin failures++; $display("FAIL basic_hi1 got=%0d exp=21", h1); end
    checks++; if (nt !== 2) begin failures++; $display("FAIL basic_nticks got=%0d exp=2", nt); end
    checks++; if (ft !== 10) begin failures++; $display("FAIL basic_first_tick got=%0d exp=10", ft); end
    checks++; if (lt !== 20) begin failures++; $display("FAIL basic_last_tick got=%0d exp=20", lt); end
    checks++; if (fh !== 0) begin failures++; $display("FAIL basic_first_hi got=%0d exp=0", fh); end
  endtask

  task automatic test_prescale();
    regs[1] = 8'd3; regs[2] = 8'd4; regs[3] = 8'd2; regs[4] = 8'd7;
    start_run(8'h83);
    run_window(40, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 16) begin failures++; $display("FAIL presc_hi0 got=%0d exp=16", h0); end
    checks++; if (h1 !== 40) begin failures++; $display("FAIL presc_hi1 got=%0d exp=40", h1); end
    checks++; if (nt !== 1) begin failures++; $display("FAIL presc_nticks got=%0d exp=1", nt); end
    checks++; if (ft !== 20) begin failures++; $display("FAIL presc_first_tick got=%0d exp=20", ft); end
  endtask

  task automatic test_duty_update();
    regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd3; regs[4] = 8'd7;
    start_run(8'h83);
    run_window(4, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 3) begin failures++; $display("FAIL upd_hi0_a got=%0d exp=3", h0); end
    regs[3] = 8'd8;
    run_window(6, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 0) begin failures++; $display("FAIL upd_hi0_b got=%0d exp=0", h0); end
    checks++; if (nt !== 0) begin failures++; $display("FAIL upd_nticks_b got=%0d exp=0", nt); end
    run_window(10, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 8) begin failures++; $display("FAIL upd_hi0_c got=%0d exp=8", h0); end
    checks++; if (ft !== 0) begin failures++; $display("FAIL upd_first_tick got=%0d exp=0", ft); end
    checks++; if (fh !== 0) begin failures++; $display("FAIL upd_first_hi got=%0d exp=0", fh); end
  endtask

  task automatic test_boundary();
    regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd0; regs[4] = 8'd10;
    start_run(8'h83);
    run_window(20, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 0) begin failures++; $display("FAIL bnd_d0_hi0 got=%0d exp=0", h0); end
    checks++; if (h1 !== 20) begin failures++; $display("FAIL bnd_dfull_hi1 got=%0d exp=20", h1); end
    checks++; if (nt !== 1) begin failures++; $display("FAIL bnd_nticks got=%0d exp=1", nt); end

    regs[1] = 8'd2; regs[2] = 8'd0; regs[3] = 8'd1; regs[4] = 8'd0;
    start_run(8'h83);
    run_window(9, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 9) begin failures++; $display("FAIL bnd_t0_hi0 got=%0d exp=9", h0); end
    checks++; if (h1 !== 0) begin failures++; $display("FAIL bnd_t0_hi1 got=%0d exp=0", h1); end
    checks++; if (nt !== 2) begin failures++; $display("FAIL bnd_t0_nticks got=%0d exp=2", nt); end
    checks++; if (ft !== 3) begin failures++; $display("FAIL bnd_t0_first_tick got=%0d exp=3", ft); end
    checks++; if (lt !== 6) begin failures++; $display("FAIL bnd_t0_last_tick got=%0d exp=6", lt); end

    regs[1] = 8'd0; regs[2] = 8'd255; regs[3] = 8'd200; regs[4] = 8'd255;
    start_run(8'h83);
    run_window(512, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 400) begin failures++; $display("FAIL bnd_t255_hi0 got=%0d exp=400", h0); end
    checks++; if (h1 !== 510) begin failures++; $display("FAIL bnd_t255_hi1 got=%0d exp=510", h1); end
    checks++; if (nt !== 1) begin failures++; $display("FAIL bnd_t255_nticks got=%0d exp=1", nt); end
    checks++; if (ft !== 256) begin failures++; $display("FAIL bnd_t255_first_tick got=%0d exp=256", ft); end
  endtask

  task automatic test_disable();
    regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd3; regs[4] = 8'd7;
    start_run(8'h83);
    step();
    regs[0] = 8'h03;
    step();
    step();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL dis_running got=%b exp=0", running); end
    checks++; if (pwm !== 2'b00) begin failures++; $display("FAIL dis_pwm got=%b exp=00", pwm); end
    regs[3] = 8'd5;
    regs[0] = 8'h83;
    step();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL reen_running got=%b exp=1", running); end
    run_window(11, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 6) begin failures++; $display("FAIL reen_hi0 got=%0d exp=6", h0); end
    checks++; if (fh !== 0) begin failures++; $display("FAIL reen_first_hi got=%0d exp=0", fh); end
    checks++; if (ft !== 10) begin failures++; $display("FAIL reen_first_tick got=%0d exp=10", ft); end
  endtask

  task automatic test_reset_mid();
    regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd3; regs[4] = 8'd7;
    start_run(8'h83);
    checks++; if (pwm !== 2'b11) begin failures++; $display("FAIL rmid_pre_pwm got=%b exp=11", pwm); end
    reset = 1'b1;
    step();
    checks++; if (pwm !== 2'b00) begin failures++; $display("FAIL rmid_pwm got=%b exp=00", pwm); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL rmid_running got=%b exp=0", running); end
    reset = 1'b0;
    step();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL rmid_restart got=%b exp=1", running); end
  endtask

`ifdef PWM_INVERT_EN
  task automatic test_invert();
    regs[1] = 8'd0; regs[2] = 8'd9; regs[3] = 8'd3; regs[4] = 8'd7;
    start_run(8'h93);
    run_window(10, h0, h1, nt, ft, lt, fh);
    checks++; if (h0 !== 7) begin failures++; $display("FAIL inv_hi0 got=%0d exp=7", h0); end
    checks++; if (h1 !== 7) begin failures++; $display("FAIL inv_hi1 got=%0d exp=7", h1); end
    checks++; if (fh !== 3) begin failures++; $display("FAIL inv_first_hi got=%0d exp=3", fh); end
    regs[0] = 8'h13;
    step();
    step();
    checks++; if (pwm !== 2'b01) begin failures++; $display("FAIL inv_idle_pwm got=%b exp=01", pwm); end
  endtask
`endif

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    test_reset();
    test_basic();
    test_prescale();
    test_duty_update();
    test_boundary();
    test_disable();
    test_reset_mid();
`ifdef PWM_INVERT_EN
    test_invert();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
